add_sub_pipe: RTL and testbench

ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

---
 rtl/add_sub_pkg.sv | 17 +
 rtl/add_sub_pipe_if.sv | 26 ++
 rtl/add_sub_stage.sv | 39 +++
 rtl/add_sub_pipe.sv | 76 +++++++
 tb/tb_add_sub_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: op encodings and op-decoding helpers shared by the add/sub pipeline
package add_sub_pkg;
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDS = 2'b10,
        OP_SUBS = 2'b11
    } op_e;

    function automatic logic is_sub(input logic [1:0] o);
        return o == OP_SUB || o == OP_SUBS;
    endfunction

    function automatic logic is_sat(input logic [1:0] o);
        return o == OP_ADDS || o == OP_SUBS;
    endfunction
endpackage

// File: rtl/add_sub_pipe_if.sv
// add_sub_pipe_if: operand/result valid-ready bus of add_sub_pipe
// Ports (signals): in_valid/in_ready/x/y/op operand beat; out_valid/out_ready/z/carry/ovf/zero/neg result beat.
// master = operand producer and result consumer; slave = the pipeline.
interface add_sub_pipe_if #(parameter int WIDTH = 32) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, x, y, op, out_ready,
        input  in_ready, out_valid, z, carry, ovf, zero, neg
    );
    modport slave (
        input  in_valid, x, y, op, out_ready,
        output in_ready, out_valid, z, carry, ovf, zero, neg
    );
endinterface

// File: rtl/add_sub_stage.sv
// add_sub_stage: half-width adder with carry in/out feeding a registered valid/ready slice
// Ports: clk, rst (async, active-high); in_valid/in_ready with a, b, cin, din (side payload);
// out_valid/out_ready with registered sum, cout, dout.
module add_sub_stage #(
    parameter int W  = 16,
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          cin,
    input  logic [DW-1:0] din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  sum,
    output logic          cout,
    output logic [DW-1:0] dout
);
    logic [W:0] s;

    assign s        = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    // load when empty or when the held beat leaves this cycle
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            dout      <= '0;
        end else begin
            if (in_ready) out_valid <= in_valid;
            if (in_valid && in_ready) {cout, sum, dout} <= {s, din};
        end
    end
endmodule

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: two-stage pipelined add/subtract with optional signed saturation
// Ports: clk, rst (async, active-high); bus (add_sub_pipe_if.slave): operand beat x, y, op in,
// result beat z with carry (carry-out / no-borrow), ovf (unsaturated signed overflow), zero, neg out.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    add_sub_pipe_if.slave     bus
);
    localparam int H = WIDTH / 2;

    logic             sub;
    logic [WIDTH-1:0] yb;
    logic             s1_valid, s2_ready, s1_c, s2_c, v, xs, ys, sat_op, ovf_raw;
    logic [H-1:0]     s1_lo, s2_hi;
    logic [2*H:0]     s1_d;
    logic [H+2:0]     s2_d;
    logic [WIDTH-1:0] raw, zf;

    // subtraction is x + ~y + 1: invert y here, inject the +1 as the low-half carry-in
    assign sub = is_sub(bus.op);
    assign yb  = sub ? ~bus.y : bus.y;

    add_sub_stage #(.W(H), .DW(2*H+1)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .a         (bus.x[H-1:0]),
        .b         (yb[H-1:0]),
        .cin       (sub),
        .din       ({is_sat(bus.op), bus.x[WIDTH-1:H], yb[WIDTH-1:H]}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .sum       (s1_lo),
        .cout      (s1_c),
        .dout      (s1_d)
    );

    // stage 2 carries the operand sign bits forward for the overflow test
    add_sub_stage #(.W(H), .DW(H+3)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .a         (s1_d[2*H-1:H]),
        .b         (s1_d[H-1:0]),
        .cin       (s1_c),
        .din       ({s1_d[2*H], s1_d[2*H-1], s1_d[H-1], s1_lo}),
        .out_valid (v),
        .out_ready (bus.out_ready),
        .sum       (s2_hi),
        .cout      (s2_c),
        .dout      (s2_d)
    );

    assign sat_op  = s2_d[H+2];
    assign xs      = s2_d[H+1];
    assign ys      = s2_d[H];
    assign raw     = {s2_hi, s2_d[H-1:0]};
    assign ovf_raw = (xs == ys) && (raw[WIDTH-1] != xs);
    // on overflow the true result has the sign of x: clamp toward it
    assign zf      = (SAT_EN && sat_op && ovf_raw) ? {xs, {(WIDTH-1){!xs}}} : raw;

    // outputs are only meaningful with a valid beat; gating keeps them zero in and after reset
    assign bus.out_valid = v;
    assign bus.z         = v ? zf : '0;
    assign bus.carry     = v && s2_c;
    assign bus.ovf       = v && ovf_raw;
    assign bus.zero      = v && (zf == '0);
    assign bus.neg       = v && zf[WIDTH-1];
endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: self-checking bench for add_sub_pipe at WIDTH 8, 16 and 32
module tb_add_sub_pipe;
    import add_sub_pkg::*;

    typedef struct {
        int          w;
        logic [1:0]  op;
        logic [31:0] x, y, z;
        logic        c, v, zr, n;
    } vec_t;

    typedef struct {
        logic [31:0] z;
        logic        c, v, zr, n;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  op = 2'b00;
    logic [31:0] x = '0, y = '0;
    int          checks = 0, failures = 0;
    res_t        q[$];

    always #5 clk = ~clk;

    add_sub_pipe_if #(.WIDTH(8))  i8 ();
    add_sub_pipe_if #(.WIDTH(16)) i16 ();
    add_sub_pipe_if #(.WIDTH(32)) i32 ();

    assign i8.in_valid   = in_valid;
    assign i8.op         = op;
    assign i8.out_ready  = out_ready;
    assign i8.x          = x[7:0];
    assign i8.y          = y[7:0];
    assign i16.in_valid  = in_valid;
    assign i16.op        = op;
    assign i16.out_ready = out_ready;
    assign i16.x         = x[15:0];
    assign i16.y         = y[15:0];
    assign i32.in_valid  = in_valid;
    assign i32.op        = op;
    assign i32.out_ready = out_ready;
    assign i32.x         = x;
    assign i32.y         = y;

    add_sub_pipe #(.WIDTH(8))  d8  (.clk(clk), .rst(rst), .bus(i8));
    add_sub_pipe #(.WIDTH(16)) d16 (.clk(clk), .rst(rst), .bus(i16));
    add_sub_pipe #(.WIDTH(32)) d32 (.clk(clk), .rst(rst), .bus(i32));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference: true signed/unsigned arithmetic on integers, then clamp
    function automatic res_t ref_model(input int w, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint unsigned m  = (64'd1 << w) - 1;
        longint unsigned ua = {32'd0, a} & m;
        longint unsigned ub = {32'd0, b} & m;
        longint unsigned u;
        longint sa, sb, t;
        sa = (ua > (m >> 1)) ? longint'(ua) - longint'(m + 1) : longint'(ua);
        sb = (ub > (m >> 1)) ? longint'(ub) - longint'(m + 1) : longint'(ub);
        if (o[0]) begin
            t   = sa - sb;
            r.c = ua >= ub;
            u   = (ua - ub) & m;
        end else begin
            t   = sa + sb;
            r.c = (ua + ub) > m;
            u   = (ua + ub) & m;
        end
        r.v = (t > longint'(m >> 1)) || (t < -longint'((m >> 1) + 1));
        if (o[1] && r.v) u = (t > 0) ? (m >> 1) : ((m >> 1) + 1);
        r.z  = u[31:0];
        r.zr = u == 0;
        r.n  = ((u >> (w - 1)) & 1) == 1;
        return r;
    endfunction

    task automatic grab(input int w, output logic ov, output logic [31:0] zz, output logic [3:0] fl);
        if (w == 8) begin
            ov = i8.out_valid;
            zz = {24'd0, i8.z};
            fl = {i8.carry, i8.ovf, i8.zero, i8.neg};
        end else if (w == 16) begin
            ov = i16.out_valid;
            zz = {16'd0, i16.z};
            fl = {i16.carry, i16.ovf, i16.zero, i16.neg};
        end else begin
            ov = i32.out_valid;
            zz = i32.z;
            fl = {i32.carry, i32.ovf, i32.zero, i32.neg};
        end
    endtask

    // random traffic on the 32-bit instance, scoreboarded against ref_model
    task automatic run(input int nb, input bit rnd, input int maxc, input string tag);
        int          sent = 0, got = 0, first = -1, last = -1;
        bit          held = 0;
        logic [35:0] prev = '0;
        res_t        e;
        for (int c = 0; c < maxc && got < nb; c++) begin
            in_valid  = sent < nb;
            x         = $urandom;
            y         = $urandom;
            op        = 2'($urandom_range(3));
            out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            #1;
            chk({tag, "_in_ready"}, i32.in_ready, q.size() < 2 || out_ready);
            if (held)
                chk({tag, "_stall_hold"}, {i32.out_valid, i32.z, i32.carry, i32.ovf, i32.zero, i32.neg}, {1'b1, prev});
            held = i32.out_valid && !out_ready;
            prev = {i32.z, i32.carry, i32.ovf, i32.zero, i32.neg};
            if (in_valid && i32.in_ready) begin
                q.push_back(ref_model(32, op, x, y));
                sent++;
            end
            if (i32.out_valid && out_ready) begin
                if (q.size() == 0) chk({tag, "_spurious_beat"}, 1, 0);
                else begin
                    e = q.pop_front();
                    chk({tag, "_z"}, i32.z, e.z);
                    chk({tag, "_flags"}, {i32.carry, i32.ovf, i32.zero, i32.neg}, {e.c, e.v, e.zr, e.n});
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            step();
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, got, nb);
        chk({tag, "_leftover"}, q.size(), 0);
        if (!rnd) chk({tag, "_one_per_cycle"}, last - first, nb - 1);
    endtask

    initial begin
        vec_t        tbl[10];
        logic        ov;
        logic [31:0] zz;
        logic [3:0]  fl;
        int          seen;
        tbl[0] = '{8,  OP_ADD,  32'hFF,       32'h01,       32'h00,       1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8,  OP_ADDS, 32'h7F,       32'h01,       32'h7F,       1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8,  OP_SUBS, 32'h80,       32'h01,       32'h80,       1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{16, OP_SUB,  32'h0003,     32'h0005,     32'hFFFE,     1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8,  OP_ADD,  32'h7F,       32'h01,       32'h80,       1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{8,  OP_SUB,  32'h05,       32'h05,       32'h00,       1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8,  OP_ADDS, 32'h80,       32'hFF,       32'h80,       1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{32, OP_SUBS, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{16, OP_ADDS, 32'h1234,     32'h0001,     32'h1235,     1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{32, OP_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out32", {i32.out_valid, i32.z, i32.carry, i32.ovf, i32.zero, i32.neg}, 0);
        chk("reset_out8", {i8.out_valid, i8.z, i8.carry, i8.ovf, i8.zero, i8.neg}, 0);
        rst = 1'b0;
        step();
        chk("reset_in_ready", {i8.in_ready, i16.in_ready, i32.in_ready}, 3'b111);

        foreach (tbl[i]) begin
            x        = tbl[i].x;
            y        = tbl[i].y;
            op       = tbl[i].op;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            grab(tbl[i].w, ov, zz, fl);
            chk($sformatf("vec%0d_early", i), ov, 0);
            step();
            grab(tbl[i].w, ov, zz, fl);
            chk($sformatf("vec%0d_valid", i), ov, 1);
            chk($sformatf("vec%0d_z", i), zz, tbl[i].z);
            chk($sformatf("vec%0d_flags", i), fl, {tbl[i].c, tbl[i].v, tbl[i].zr, tbl[i].n});
            step();
            grab(tbl[i].w, ov, zz, fl);
            chk($sformatf("vec%0d_single", i), ov, 0);
        end

        run(100, 1'b0, 200, "b2b");
        run(150, 1'b1, 1000, "stall");

        // fill both stages, then reset mid-cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            x  = $urandom;
            y  = $urandom;
            op = 2'($urandom_range(3));
            step();
        end
        chk("full_valid", i32.out_valid, 1);
        chk("full_in_ready", i32.in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out", {i32.out_valid, i32.z, i32.carry, i32.ovf, i32.zero, i32.neg}, 0);
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        q.delete();
        seen = 0;
        repeat (4) begin
            step();
            if (i32.out_valid) seen++;
        end
        chk("rst_no_stale", seen, 0);
        chk("rst_in_ready", i32.in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
